map_bram_arb: RTL and testbench
===============================

# map_bram_arb

Single-port arbiter for the shared map block RAM. It lets several map clients take turns on the one BRAM port: the player interaction logic, enemy/AI logic and the level loader. It grants one transaction at a time, drives the BRAM address, write-enable and write-data, and returns read data tagged to the winning requester. It sits between the map clients and the map BRAM, so each client no longer drives the BRAM port directly.

## Interface
- NREQ, 3, number of requesters (1..8)
- ADDR_W, 19, BRAM address width
- DATA_W, 16, BRAM data width
- RD_LAT, 1, BRAM read latency in clocks (1..4), from address presented to data valid
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-client request, level, held until gnt
- req_wr  in  NREQ  per-client 1=write, 0=read
- req_addr  in  NREQ*ADDR_W  client i at bits [i*ADDR_W +: ADDR_W]
- req_dwrite  in  NREQ*DATA_W  client i at bits [i*DATA_W +: DATA_W]
- gnt  out  NREQ  one-cycle one-hot grant pulse
- rvalid  out  NREQ  one-cycle one-hot read-data-valid pulse
- rdata  out  DATA_W  read data, shared, qualified by rvalid
- busy  out  1  high whenever state is not IDLE
- bram_addr  out  ADDR_W  BRAM address
- bram_wr  out  1  BRAM write enable
- bram_dwrite  out  DATA_W  BRAM write data
- bram_data  in  DATA_W  BRAM read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPT. Reset state is IDLE.
- IDLE:
  - If any req bit is high, select winner w.
  - Register req_addr[w], req_dwrite[w] and req_wr[w] into bram_addr, bram_dwrite and an internal wr flag.
  - Set owner=w and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt[owner]=1.
  - bram_wr equals the wr flag.
  - Write: go to IDLE.
  - Read: load the wait counter with RD_LAT-1 and go to WAIT. If RD_LAT=1, go straight to CAPT.
- WAIT: decrement the counter each cycle. When it reaches 0, go to CAPT.
- CAPT: register bram_data into rdata, pulse rvalid[owner] in the following cycle, and go to IDLE.
- Only one transaction is outstanding at a time. req is sampled only in IDLE.
- Requester rule: hold req, req_wr, req_addr and req_dwrite stable until gnt is seen. Drop req in the cycle after gnt, unless another transaction is wanted. A req still high when the FSM re-enters IDLE counts as a new request.
- Reset values:
  - gnt=0, rvalid=0, rdata=0, busy=0
  - bram_addr=0, bram_wr=0, bram_dwrite=0
  - owner=0, rr pointer=0
- bram_addr and bram_dwrite hold their last value between transactions. bram_wr is 1 only in ISSUE of a write.
- Reset asserted mid-transaction aborts it immediately. No rvalid is produced and no bram_wr pulse follows.

## Timing
- The IDLE decision happens in cycle T.
- gnt and bram_addr/bram_wr are valid in cycle T+1.
- Write throughput: 2 cycles per transaction.
- Read:
  - BRAM data is valid in cycle T+1+RD_LAT, which is the CAPT cycle.
  - rvalid and rdata are valid in cycle T+2+RD_LAT.
  - Throughput is 2+RD_LAT cycles per read.
- gnt and rvalid are registered outputs, one-hot or zero, and never high for more than 1 cycle per transaction.
- Simultaneous requests in IDLE are resolved by the priority policy under Configuration. Losers remain pending and carry no penalty.
- NREQ=1: the arbiter degenerates to a sequencer, with the same cycle behaviour.

## Configuration
- MAP_ARB_RR_EN defined: round-robin arbitration.
  - Search starts at the rr pointer.
  - After each grant, pointer = owner+1, wrapping from NREQ-1 to 0.
  - A client continuously requesting waits at most NREQ-1 transactions.
- MAP_ARB_RR_EN undefined: fixed priority, lowest index wins. The rr pointer is not implemented.

## Test plan
- Reset, then client 0 writes addr 0x00123 data 0xBEEF. Required: bram_wr=1 for exactly 1 cycle at T+1 with that addr/data, gnt=001 at T+1, no rvalid.
- RD_LAT=2, client 1 reads addr 0x00045 with the BRAM model returning 0x1234. Required: gnt=010 at T+1, rvalid=010 at T+4, rdata=0x1234.
- All 3 clients request reads continuously with MAP_ARB_RR_EN defined. Required: grant order 0,1,2,0,1,2. Without the macro: client 0 is granted every transaction.
- Client 2 requests in the CAPT cycle of client 0's read. Required: client 2 is not granted before IDLE, then gnt=100 exactly 1 cycle after IDLE.
- Assert rstn low during WAIT of a read. Required: all outputs return to 0 asynchronously, no rvalid afterwards, FSM in IDLE with busy=0.
- A write by client 1 followed by a read by client 0 of the same addr. Required: the read returns the written value, with rvalid=001.

Source files
------------

// File: rtl/map_bram_arb.sv
`default_nettype none
// ============================================================================
// map_bram_arb : single-port arbiter sharing the map BRAM among NREQ clients,
//                one transaction at a time, read data tagged to the owner.
// Optional feature macro: MAP_ARB_RR_EN (round-robin instead of fixed priority)
// Revision: 1.0
// ============================================================================

module map_bram_arb #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_dwrite,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic                     bram_wr,
  output logic [DATA_W-1:0]        bram_dwrite,
  input  logic [DATA_W-1:0]        bram_data
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CAPT  = 2'd3
  } state_t;

  state_t          state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   win;
  logic            any_req;
  logic            wr_flag;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] own_oh;

`ifdef MAP_ARB_RR_EN
  logic [OW-1:0]   rr_ptr;
  logic [OW-1:0]   rr_next;

  // Circular search starting at the pointer; first requester found wins.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win     = OW'(idx);
      end
    end
  end

  assign rr_next = (int'(win) == NREQ - 1) ? '0 : win + OW'(1);
`else
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_req && req[k]) begin
        any_req = 1'b1;
        win     = OW'(k);
      end
    end
  end
`endif

  always_comb begin
    win_oh = '0;
    own_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_oh[i] = (win == OW'(i));
      own_oh[i] = (owner == OW'(i));
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      owner       <= '0;
      wr_flag     <= 1'b0;
      cnt         <= '0;
      gnt         <= '0;
      rvalid      <= '0;
      rdata       <= '0;
      bram_addr   <= '0;
      bram_wr     <= 1'b0;
      bram_dwrite <= '0;
`ifdef MAP_ARB_RR_EN
      rr_ptr      <= '0;
`endif
    end else begin
      // Pulse outputs default low; each is set for exactly one cycle below.
      gnt     <= '0;
      rvalid  <= '0;
      bram_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            bram_addr   <= req_addr[int'(win)*ADDR_W +: ADDR_W];
            bram_dwrite <= req_dwrite[int'(win)*DATA_W +: DATA_W];
            wr_flag     <= req_wr[win];
            bram_wr     <= req_wr[win];
            owner       <= win;
            gnt         <= win_oh;
            state       <= S_ISSUE;
`ifdef MAP_ARB_RR_EN
            rr_ptr      <= rr_next;
`endif
          end
        end
        S_ISSUE: begin
          if (wr_flag) begin
            state <= S_IDLE;
          end else if (RD_LAT <= 1) begin
            state <= S_CAPT;
          end else begin
            cnt   <= CW'(RD_LAT - 1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CW'(1)) state <= S_CAPT;
        end
        S_CAPT: begin
          rdata  <= bram_data;
          rvalid <= own_oh;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_map_bram_arb.sv
`default_nettype none
// ============================================================================
// tb_map_bram_arb : randomized + directed scoreboard bench for map_bram_arb.
// Revision: 1.0
// ============================================================================

module tb_map_bram_arb;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 2;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_dwrite;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;
  logic [ADDR_W-1:0]      bram_addr;
  logic                   bram_wr;
  logic [DATA_W-1:0]      bram_dwrite;
  logic [DATA_W-1:0]      bram_data;

  always #5 clk = ~clk;

  map_bram_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_dwrite(req_dwrite), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .bram_addr(bram_addr), .bram_wr(bram_wr), .bram_dwrite(bram_dwrite), .bram_data(bram_data)
  );

  function automatic logic [15:0] pat(input int a);
    logic [15:0] v;
    v = 16'(a * 257) ^ 16'h5A5A;
    if (a == 32'h45) v = 16'h1234;
    return v;
  endfunction

  // BRAM environment model: synchronous write, RD_LAT-deep read pipeline.
  logic [DATA_W-1:0] bmem [0:511];
  logic [DATA_W-1:0] pipe [0:RD_LAT-1];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int a = 0; a < 512; a++) bmem[a] <= pat(a);
      loaded <= 1'b1;
    end else if (bram_wr) begin
      bmem[bram_addr[8:0]] <= bram_dwrite;
    end
    pipe[0] <= bmem[bram_addr[8:0]];
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bram_data = pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cl; bit wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } txn_t;
  typedef struct { int cyc; logic [NREQ-1:0] oh; bit wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } exp_t;

  txn_t            pend[$];
  txn_t            cur[NREQ];
  bit [NREQ-1:0]   active = '0;
  exp_t            gq[$];
  exp_t            rq[$];
  int              glog[$];
  logic [DATA_W-1:0] ref_mem [0:511];
  int              idle_at = 0;
  int              rr = 0;
  int              checks = 0;
  int              passed = 0;
  exp_t            me;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  function automatic int find_pend(input int i);
    for (int j = 0; j < pend.size(); j++) if (pend[j].cl == i) return j;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  task automatic push_txn(input int cl, input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    txn_t t;
    t.cl = cl; t.wr = wr; t.addr = a; t.data = d;
    pend.push_back(t);
  endtask

  // Reference model: when the arbiter is idle, pick a winner from the live
  // request vector and predict gnt / rvalid cycles and data.
  task automatic model_step();
    int w;
    exp_t e;
    if (cyc < idle_at || req == '0) return;
    w = -1;
`ifdef MAP_ARB_RR_EN
    for (int k = 0; k < NREQ; k++) if (w < 0 && req[(rr + k) % NREQ]) w = (rr + k) % NREQ;
    rr = (w + 1) % NREQ;
`else
    for (int k = 0; k < NREQ; k++) if (w < 0 && req[k]) w = k;
`endif
    e.oh = '0;
    e.oh[w] = 1'b1;
    e.cyc = cyc + 1;
    e.wr = cur[w].wr;
    e.addr = cur[w].addr;
    e.data = cur[w].data;
    gq.push_back(e);
    if (cur[w].wr) begin
      ref_mem[cur[w].addr[8:0]] = cur[w].data;
      idle_at = cyc + 2;
    end else begin
      e.cyc = cyc + 2 + RD_LAT;
      e.data = ref_mem[cur[w].addr[8:0]];
      rq.push_back(e);
      idle_at = cyc + 2 + RD_LAT;
    end
  endtask

  // Requester driver: hold until gnt, then drop or present the next transaction.
  initial begin
    int j;
    for (int a = 0; a < 512; a++) ref_mem[a] = pat(a);
    req = '0; req_wr = '0; req_addr = '0; req_dwrite = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        req = '0;
        active = '0;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (active[i] && gnt[i]) begin
            active[i] = 1'b0;
            req[i] = 1'b0;
          end
          if (!active[i]) begin
            j = find_pend(i);
            if (j >= 0) begin
              cur[i] = pend[j];
              pend.delete(j);
              active[i] = 1'b1;
              req[i] = 1'b1;
              req_wr[i] = cur[i].wr;
              req_addr[i*ADDR_W +: ADDR_W] = cur[i].addr;
              req_dwrite[i*DATA_W +: DATA_W] = cur[i].data;
            end
          end
        end
        model_step();
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents gnt/bram_wr or rvalid.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (gnt != '0 || bram_wr) begin
        if (gnt != '0) glog.push_back(oh_idx(gnt));
        if (gq.size() == 0) chk("gnt_unexpected", {gnt, bram_wr}, '0);
        else begin
          me = gq.pop_front();
          chk("gnt_cycle", cyc, me.cyc);
          chk("gnt_vec", gnt, me.oh);
          chk("gnt_bram_wr", bram_wr, me.wr);
          chk("gnt_bram_addr", bram_addr, me.addr);
          if (me.wr) chk("gnt_bram_dwrite", bram_dwrite, me.data);
        end
      end else if (gq.size() != 0 && gq[0].cyc < cyc) begin
        me = gq.pop_front();
        chk("gnt_missing", gnt, me.oh);
      end
      if (rvalid != '0) begin
        if (rq.size() == 0) chk("rvalid_unexpected", rvalid, '0);
        else begin
          me = rq.pop_front();
          chk("rvalid_cycle", cyc, me.cyc);
          chk("rvalid_vec", rvalid, me.oh);
          chk("rdata", rdata, me.data);
        end
      end else if (rq.size() != 0 && rq[0].cyc < cyc) begin
        me = rq.pop_front();
        chk("rvalid_missing", rvalid, me.oh);
      end
    end
  end

  task automatic wait_gnt(input int i, output int at);
    at = -1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (gnt[i]) begin at = cyc; break; end
    end
    if (at < 0) chk("gnt_timeout", gnt, NREQ'(1) << i);
  endtask

  task automatic wait_rv(input int i, output int at);
    at = -1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (rvalid[i]) begin at = cyc; break; end
    end
    if (at < 0) chk("rvalid_timeout", rvalid, NREQ'(1) << i);
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (pend.size() == 0 && active == '0 && gq.size() == 0 && rq.size() == 0 && !busy) break;
      @(negedge clk);
    end
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", checks);
    $fatal(1);
  end

  initial begin
    int g, r;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, '0);
    chk("rst_rvalid", rvalid, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bram_addr", bram_addr, '0);
    chk("rst_bram_wr", bram_wr, 1'b0);
    chk("rst_bram_dwrite", bram_dwrite, '0);
    rstn = 1'b1;
    @(negedge clk); #1;

    // Client 0 single write
    push_txn(0, 1'b1, 19'h00123, 16'hBEEF);
    wait_gnt(0, g);
    chk("t1_gnt", gnt, 3'b001);
    chk("t1_bram_wr", bram_wr, 1'b1);
    chk("t1_addr", bram_addr, 19'h00123);
    chk("t1_data", bram_dwrite, 16'hBEEF);
    chk("t1_rvalid", rvalid, '0);
    @(negedge clk);
    chk("t1_wr_one_cycle", bram_wr, 1'b0);
    chk("t1_gnt_one_cycle", gnt, '0);
    drain();

    // Client 1 read, latency check
    push_txn(1, 1'b0, 19'h00045, 16'h0000);
    wait_gnt(1, g);
    chk("t2_gnt", gnt, 3'b010);
    wait_rv(1, r);
    chk("t2_latency", r - g, RD_LAT + 1);
    chk("t2_rvalid", rvalid, 3'b010);
    chk("t2_rdata", rdata, 16'h1234);
    drain();

    // Client 2 arrives during CAPT of a client 0 read
    push_txn(0, 1'b0, 19'h00033, 16'h0000);
    wait_gnt(0, g);
    @(negedge clk); #1;
    push_txn(2, 1'b0, 19'h00010, 16'h0000);
    @(negedge clk);
    chk("t4_capt_no_gnt", gnt, '0);
    chk("t4_capt_busy", busy, 1'b1);
    @(negedge clk);
    chk("t4_idle_rvalid", rvalid, 3'b001);
    chk("t4_idle_no_gnt", gnt, '0);
    @(negedge clk);
    chk("t4_gnt_after_idle", gnt, 3'b100);
    drain();

    // Three clients reading continuously
    glog.delete();
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < NREQ; i++) push_txn(i, 1'b0, 19'($urandom_range(0, 63)), 16'h0);
    for (int t = 0; t < 200 && glog.size() < 6; t++) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
`ifdef MAP_ARB_RR_EN
      chk("t3_order", (k < glog.size()) ? glog[k] : -1, k % NREQ);
`else
      chk("t3_order", (k < glog.size()) ? glog[k] : -1, 0);
`endif
    end
    drain();

    // Write by client 1 then read back by client 0
    push_txn(1, 1'b1, 19'h000AB, 16'hC0DE);
    wait_gnt(1, g);
    #1;
    push_txn(0, 1'b0, 19'h000AB, 16'h0000);
    wait_rv(0, r);
    chk("t6_rvalid", rvalid, 3'b001);
    chk("t6_rdata", rdata, 16'hC0DE);
    drain();

    // Reset in WAIT of a read
    push_txn(0, 1'b0, 19'h00077, 16'h0000);
    wait_gnt(0, g);
    @(posedge clk); #1;
    rstn = 1'b0;
    gq.delete(); rq.delete(); pend.delete();
    idle_at = 0; rr = 0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_gnt", gnt, '0);
    chk("t5_rvalid", rvalid, '0);
    chk("t5_rdata", rdata, '0);
    chk("t5_bram_addr", bram_addr, '0);
    chk("t5_bram_wr", bram_wr, 1'b0);
    chk("t5_bram_dwrite", bram_dwrite, '0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int t = 0; t < RD_LAT + 4; t++) begin
      @(negedge clk);
      chk("t5_no_rvalid", rvalid, '0);
      chk("t5_no_bram_wr", bram_wr, 1'b0);
    end
    #1;

    // Randomized traffic
    for (int t = 0; t < 500; t++) begin
      @(negedge clk); #1;
      for (int i = 0; i < NREQ; i++)
        if (find_pend(i) < 0 && $urandom_range(0, 3) == 0)
          push_txn(i, 1'($urandom_range(0, 1)), 19'($urandom_range(0, 31)), 16'($urandom));
    end
    drain();
    chk("end_gq_empty", gq.size(), 0);
    chk("end_rq_empty", rq.size(), 0);
    chk("end_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
